tdm_demux14_4: RTL and testbench
================================

TDM_DEMUX14_4 -- requirements
Module: tdm_demux14_4

Interface
REQ-001 Parameter W, default 4: data width of the input stream and of each output channel.
REQ-002 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_valid  input  1  input beat present this cycle.
REQ-005 i_sync  input  1  beat is slot 0 of a frame; qualified by i_valid.
REQ-006 i_d  input  W  beat data.
REQ-007 o_f0, o_f1, o_f2, o_f3  output  W each  channel outputs; registered; hold the last complete frame.
REQ-008 o_frame_valid  output  1  one-cycle pulse; o_f0..o_f3 updated this cycle.
REQ-009 o_locked  output  1  high while in state LOCKED.
REQ-010 o_err  output  1  one-cycle pulse on a framing error.

Function
REQ-011 A frame SHALL be 4 accepted beats, slot 0..3; i_sync high on slot 0 only.
REQ-012 State machine SHALL have states UNLOCKED and LOCKED, plus a 2-bit slot counter and four W-bit staging registers.
REQ-013 In UNLOCKED, beats with i_sync=0 SHALL be discarded without error.
REQ-014 In UNLOCKED, a beat with i_sync=1 SHALL be written to staging[0], set the counter to 1 and move to LOCKED.
REQ-015 In LOCKED, a beat with i_sync=0 and counter!=0 SHALL be written to staging[counter], then the counter SHALL increment.
REQ-016 When the slot-3 beat is accepted, the counter SHALL wrap to 0.
REQ-017 In the same edge as REQ-016, o_f0..o_f2 SHALL load staging[0..2] and o_f3 SHALL load i_d.
REQ-018 In the same edge as REQ-016, o_frame_valid SHALL be set for one cycle. Latency from slot-3 beat to outputs is 1 cycle.
REQ-019 o_f0..o_f3 SHALL change only on a frame completion, so all four channels always come from the same frame.
REQ-020 In LOCKED, i_sync=1 with counter!=0 (early sync) SHALL pulse o_err and discard the partial frame. The beat SHALL be treated as slot 0: it is written to staging[0], the counter is set to 1 and the state stays LOCKED.
REQ-021 In LOCKED, i_sync=1 with counter==0 SHALL be a normal slot-0 beat.
REQ-022 In LOCKED, i_sync=0 with counter==0 (missing sync) SHALL pulse o_err, discard the beat and move to UNLOCKED.
REQ-023 Cycles with i_valid=0 SHALL not change state, counter, staging or outputs. Gaps of any length between beats are legal.
REQ-024 i_sync with i_valid=0 SHALL be ignored.
REQ-025 o_err and o_frame_valid SHALL never be high in the same cycle.
REQ-026 Each of o_err and o_frame_valid SHALL be high for exactly one cycle per event.

Reset
REQ-027 While i_rst_n=0, state SHALL be UNLOCKED, the counter 0, staging all 0 and o_f0..o_f3 all 0.
REQ-028 While i_rst_n=0, o_frame_valid, o_err and o_locked SHALL be 0.
REQ-029 Reset SHALL act immediately, independent of i_clk.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame. After release, the first frame SHALL require a fresh sync.
REQ-031 The first accepted beat SHALL be on the first rising edge after i_rst_n deasserts.

Verification
REQ-032 Aligned frame: beats 0x1(sync), 0x2, 0x3, 0x4 on consecutive cycles -> one cycle after the last beat, o_f0..o_f3 = 1,2,3,4, o_frame_valid pulses once, o_locked=1.
REQ-033 Gaps and back-to-back: same frame with 2 idle cycles between beats, then a second frame 0xA..0xD (sync on 0xA) with no gap -> outputs 1,2,3,4 held until the second frame completes, then A,B,C,D. No o_err.
REQ-034 Pre-lock garbage: beats 0x7, 0x8 without sync, then an aligned frame 5,6,7,8 -> no o_err. o_locked rises after the sync beat; outputs become 5,6,7,8.
REQ-035 Early sync: sync 0x1, 0x2, then sync 0x9, 0xA, 0xB, 0xC -> o_err pulses on the second sync; outputs become 9,A,B,C; the 1,2 partial frame never appears.
REQ-036 Missing sync: after a complete frame, a beat 0xE without sync -> o_err pulses, o_locked=0, outputs unchanged. The next sync frame 1,2,3,4 relocks and updates the outputs.
REQ-037 Reset mid-frame: after sync 0x3, 0x4, assert i_rst_n=0 between clock edges -> all outputs 0 immediately. After release, beats 0x5, 0x6 without sync are ignored.

Source files
------------

// File: rtl/tdm_demux14_4.sv
// 4-slot TDM demultiplexer: a framed stream of W-bit beats (sync on slot 0)
// is collected into staging registers and presented on four channel outputs
// once a complete frame has arrived.
module tdm_demux14_4 #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  input  logic         i_sync,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_f0,
  output logic [W-1:0] o_f1,
  output logic [W-1:0] o_f2,
  output logic [W-1:0] o_f3,
  output logic         o_frame_valid,
  output logic         o_locked,
  output logic         o_err
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] stg_q [4];
  logic [W-1:0] stg_d [4];
  logic [W-1:0] f_q [4];
  logic [W-1:0] f_d [4];
  logic         fv_q, fv_d;
  logic         err_q, err_d;

  // Next-state decode: only accepted beats move anything; pulses default low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stg_d   = stg_q;
    f_d     = f_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;
    if (i_valid) begin
      if (state_q == UNLOCKED) begin
        // Garbage before the first sync is silently dropped.
        if (i_sync) begin
          stg_d[0] = i_d;
          cnt_d    = 2'd1;
          state_d  = LOCKED;
        end
      end else begin
        if (i_sync) begin
          // A sync mid-frame restarts the frame; the partial one is lost.
          err_d    = (cnt_q != 2'd0);
          stg_d[0] = i_d;
          cnt_d    = 2'd1;
        end else if (cnt_q == 2'd0) begin
          // Slot 0 without sync: alignment lost, beat dropped.
          err_d   = 1'b1;
          state_d = UNLOCKED;
        end else begin
          stg_d[cnt_q] = i_d;
          cnt_d        = 2'(cnt_q + 2'd1);
          if (cnt_q == 2'd3) begin
            // Frame complete: publish all four slots together.
            f_d[0] = stg_q[0];
            f_d[1] = stg_q[1];
            f_d[2] = stg_q[2];
            f_d[3] = i_d;
            fv_d   = 1'b1;
          end
        end
      end
    end
  end

  // State register with immediate reset of framing state and outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= UNLOCKED;
      cnt_q   <= 2'd0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        stg_q[i] <= '0;
        f_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
      stg_q   <= stg_d;
      f_q     <= f_d;
    end
  end

  assign o_f0          = f_q[0];
  assign o_f1          = f_q[1];
  assign o_f2          = f_q[2];
  assign o_f3          = f_q[3];
  assign o_frame_valid = fv_q;
  assign o_err         = err_q;
  assign o_locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux14_4.sv
// Directed bench for tdm_demux14_4: framed beat sequences with hand-computed
// channel values, error/frame pulse counts and asynchronous reset behaviour.
module tb_tdm_demux14_4;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_valid;
  logic       i_sync;
  logic [3:0] i_d;
  logic [3:0] o_f0, o_f1, o_f2, o_f3;
  logic       o_frame_valid;
  logic       o_locked;
  logic       o_err;

  int n_checks = 0;
  int n_errors = 0;
  int err_pulses = 0;
  int fv_pulses = 0;
  int overlaps = 0;

  tdm_demux14_4 #(.W(4)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .i_sync       (i_sync),
    .i_d          (i_d),
    .o_f0         (o_f0),
    .o_f1         (o_f1),
    .o_f2         (o_f2),
    .o_f3         (o_f3),
    .o_frame_valid(o_frame_valid),
    .o_locked     (o_locked),
    .o_err        (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Pulse monitor: each one-cycle pulse is seen at exactly one falling edge.
  always @(negedge i_clk) begin
    if (o_err) err_pulses++;
    if (o_frame_valid) fv_pulses++;
    if (o_err && o_frame_valid) overlaps++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
    chk({tag, ".f0"}, 32'(o_f0), 32'(a));
    chk({tag, ".f1"}, 32'(o_f1), 32'(b));
    chk({tag, ".f2"}, 32'(o_f2), 32'(c));
    chk({tag, ".f3"}, 32'(o_f3), 32'(d));
  endtask

  // One accepted beat; returns 1 time unit after the accepting edge.
  task automatic beat(input logic s, input logic [3:0] d);
    i_valid = 1'b1;
    i_sync  = s;
    i_d     = d;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_sync  = 1'b0;
  endtask

  // Idle cycle; sync may be high to show it is ignored without valid.
  task automatic idle(input logic s);
    i_valid = 1'b0;
    i_sync  = s;
    i_d     = 4'hF;
    @(posedge i_clk);
    #1;
    i_sync  = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_sync  = 1'b0;
    i_d     = 4'h0;
    repeat (2) @(posedge i_clk);
    #1;
    chk_frame("reset", 4'h0, 4'h0, 4'h0, 4'h0);
    chk("reset.locked", 32'(o_locked), 32'd0);
    chk("reset.fv", 32'(o_frame_valid), 32'd0);
    chk("reset.err", 32'(o_err), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Aligned frame 1,2,3,4.
    beat(1'b1, 4'h1);
    chk("aligned.locked_after_sync", 32'(o_locked), 32'd1);
    beat(1'b0, 4'h2);
    beat(1'b0, 4'h3);
    chk("aligned.no_fv_early", 32'(o_frame_valid), 32'd0);
    beat(1'b0, 4'h4);
    chk("aligned.fv", 32'(o_frame_valid), 32'd1);
    chk("aligned.locked", 32'(o_locked), 32'd1);
    chk_frame("aligned", 4'h1, 4'h2, 4'h3, 4'h4);
    idle(1'b0);
    chk("aligned.fv_one_cycle", 32'(o_frame_valid), 32'd0);

    // Gapped frame 1..4 (sync during gaps must be ignored), then A..D back-to-back.
    beat(1'b1, 4'h1); idle(1'b1); idle(1'b0);
    beat(1'b0, 4'h2); idle(1'b1); idle(1'b0);
    beat(1'b0, 4'h3); idle(1'b0); idle(1'b1);
    beat(1'b0, 4'h4);
    chk("gap.fv", 32'(o_frame_valid), 32'd1);
    chk_frame("gap", 4'h1, 4'h2, 4'h3, 4'h4);
    beat(1'b1, 4'hA);
    beat(1'b0, 4'hB);
    beat(1'b0, 4'hC);
    chk_frame("b2b.hold", 4'h1, 4'h2, 4'h3, 4'h4);
    beat(1'b0, 4'hD);
    chk("b2b.fv", 32'(o_frame_valid), 32'd1);
    chk_frame("b2b", 4'hA, 4'hB, 4'hC, 4'hD);
    chk("b2b.err_count", 32'(err_pulses), 32'd0);

    // Missing sync after a complete frame.
    beat(1'b0, 4'hE);
    chk("miss.err", 32'(o_err), 32'd1);
    chk("miss.locked", 32'(o_locked), 32'd0);
    chk_frame("miss.hold", 4'hA, 4'hB, 4'hC, 4'hD);

    // Pre-lock garbage then aligned frame 5..8.
    beat(1'b0, 4'h7);
    chk("garbage.err", 32'(o_err), 32'd0);
    beat(1'b0, 4'h8);
    chk("garbage.locked", 32'(o_locked), 32'd0);
    beat(1'b1, 4'h5);
    chk("relock.locked", 32'(o_locked), 32'd1);
    beat(1'b0, 4'h6);
    beat(1'b0, 4'h7);
    beat(1'b0, 4'h8);
    chk_frame("relock", 4'h5, 4'h6, 4'h7, 4'h8);
    chk("relock.err_count", 32'(err_pulses), 32'd1);

    // Early sync: 1,2 partial discarded, 9..C published.
    beat(1'b1, 4'h1);
    beat(1'b0, 4'h2);
    beat(1'b1, 4'h9);
    chk("early.err", 32'(o_err), 32'd1);
    chk("early.locked", 32'(o_locked), 32'd1);
    beat(1'b0, 4'hA);
    chk("early.err_one_cycle", 32'(o_err), 32'd0);
    beat(1'b0, 4'hB);
    beat(1'b0, 4'hC);
    chk("early.fv", 32'(o_frame_valid), 32'd1);
    chk_frame("early", 4'h9, 4'hA, 4'hB, 4'hC);

    // Reset mid-frame, asserted between edges.
    beat(1'b1, 4'h3);
    beat(1'b0, 4'h4);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk_frame("rst_async", 4'h0, 4'h0, 4'h0, 4'h0);
    chk("rst_async.locked", 32'(o_locked), 32'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    beat(1'b0, 4'h5);
    beat(1'b0, 4'h6);
    chk("post_rst.locked", 32'(o_locked), 32'd0);
    chk("post_rst.err", 32'(o_err), 32'd0);
    beat(1'b0, 4'h7);
    beat(1'b0, 4'h8);
    chk_frame("post_rst.ignored", 4'h0, 4'h0, 4'h0, 4'h0);
    beat(1'b1, 4'h1);
    beat(1'b0, 4'h2);
    beat(1'b0, 4'h3);
    beat(1'b0, 4'h4);
    chk_frame("post_rst.frame", 4'h1, 4'h2, 4'h3, 4'h4);
    idle(1'b0);

    chk("total.err_pulses", 32'(err_pulses), 32'd2);
    chk("total.fv_pulses", 32'(fv_pulses), 32'd6);
    chk("total.overlap", 32'(overlaps), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
